ic_cpu_bus_axi_bridge_pipe: RTL and testbench
=============================================

Name: ic_cpu_bus_axi_bridge_pipe

Overview:
- Parametrised, pipelined successor to the single-transaction CPU-bus-to-AXI4-Lite bridge.
- Converts the CPU request/response memory port into the five AXI4-Lite channels.
- Data width and the number of outstanding transactions are parameters; multiple same-direction transactions may be in flight.
- Responses return to the CPU strictly in request order, and AXI error responses are reported on the CPU port.

Parameters:
- DW, 32, data width in bits; 32 or 64; strobe width is DW/8.
- AW, 32, address width in bits.
- DEPTH, 4, maximum outstanding transactions; range 1..16.
- PROT, 3'b000, constant driven on m0_awprot and m0_arprot.

Ports:
- m0_aclk  in  1  clock.
- m0_areset  in  1  asynchronous, active-high reset.
- m0_awvalid/m0_awready  out/in  1/1  write-address handshake.
- m0_awaddr  out  AW  write address.
- m0_awprot  out  3  = PROT.
- m0_wvalid/m0_wready  out/in  1/1  write-data handshake.
- m0_wdata  out  DW  write data.
- m0_wstrb  out  DW/8  write strobe.
- m0_bvalid/m0_bready  in/out  1/1  write-response handshake.
- m0_bresp  in  2  write response.
- m0_arvalid/m0_arready  out/in  1/1  read-address handshake.
- m0_araddr  out  AW  read address.
- m0_arprot  out  3  = PROT.
- m0_rvalid/m0_rready  in/out  1/1  read-response handshake.
- m0_rresp  in  2  read response.
- m0_rdata  in  DW  read data.
- enable  in  1  request admission enable.
- mem_req/mem_gnt  in/out  1/1  CPU request handshake.
- mem_wen  in  1  write enable.
- mem_strb  in  DW/8  write strobe.
- mem_wdata  in  DW  write data.
- mem_addr  in  AW  address.
- mem_recv/mem_ack  out/in  1/1  CPU response handshake.
- mem_error  out  1  response error.
- mem_rdata  out  DW  read data.

Behaviour:
- Reset values (asynchronous on m0_areset=1): all *valid outputs 0; m0_rready=0, m0_bready=0; mem_gnt=0, mem_recv=0, mem_error=0. Outstanding count=0, direction=read, holding register empty, address/data/strobe buffers 0. Reset mid-transaction abandons all in-flight work; no response is produced for it afterwards.
- Events:
  - cpu_req = mem_req & mem_gnt
  - cpu_rsp = mem_recv & mem_ack
  - ar/aw/w/r/b handshakes = valid & ready on the respective channel.
- Grant: mem_gnt = enable & holding register empty & count<DEPTH & (count==0 | dir==mem_wen).
  - A direction change waits until count==0.
  - mem_gnt does not depend on mem_req.
- On cpu_req, capture addr/wdata/strb into the holding register, set dir=mem_wen, and increment count.
  - Read: set ar_pend. Write: set aw_pend and w_pend.
  - Valids assert the cycle after grant (1-cycle request latency).
- Channel drive and pending flags:
  - m0_arvalid=ar_pend; m0_awvalid=aw_pend; m0_wvalid=w_pend.
  - Each flag clears on its own handshake, independently. AW and W may complete in either order or in the same cycle.
  - The holding register is empty when all three flags are 0.
  - While a valid is high and not accepted, it and its payload stay stable.
- Responses:
  - mem_recv = count!=0 & (dir ? m0_bvalid : m0_rvalid).
  - m0_rready = !dir & mem_recv & mem_ack; m0_bready = dir & mem_recv & mem_ack.
  - mem_rdata = m0_rdata (combinational).
  - mem_error = dir ? m0_bresp[1] : m0_rresp[1] (SLVERR/DECERR → 1).
- Count:
  - +1 on cpu_req, -1 on cpu_rsp.
  - Both in the same cycle: unchanged.
  - Width clog2(DEPTH+1); it never exceeds DEPTH and never wraps below 0.
- A response arriving with count==0, or on the channel opposite to dir, is not accepted (ready held 0).
- enable=0 blocks new grants only; in-flight transactions drain normally.

Test Plan:
- Single read: addr=0x1000, rdata=0xDEADBEEF, arready=1, rvalid 2 cycles later, ack=1 → arvalid 1 cycle after grant, mem_recv with rdata 0xDEADBEEF, mem_error=0, count returns to 0.
- Split write: addr=0x20, wdata=0x12345678, strb=4'hF, wready 3 cycles before awready → both payloads stable while pending; bresp=2'b10 → mem_error=1.
- Pipelining, DEPTH=4: 4 back-to-back reads with arready=1 and no rvalid → 4 grants, then mem_gnt=0. Return 4 rvalid beats with ack=1 → data delivered in order, count returns to 0.
- Direction switch: write granted while 2 reads are outstanding → mem_gnt stays 0 until the second read response is acked; the write is then granted the next cycle.
- Backpressure: rvalid=1, mem_ack=0 for 5 cycles → rready=0 and count unchanged; ack=1 → rready=1 that cycle, count-1.
- Reset mid-operation: assert m0_areset while arvalid=1 → arvalid=0 immediately (asynchronous), count=0; a stray rvalid after release is not accepted.

Source files
------------

// File: rtl/ic_cpu_bus_axi_bridge_pipe.sv
// ic_cpu_bus_axi_bridge_pipe: pipelined CPU request/response port to AXI4-Lite master bridge
// with in-order responses and up to DEPTH same-direction transactions in flight.
module ic_cpu_bus_axi_bridge_pipe #(
    parameter int DW = 32,
    parameter int AW = 32,
    parameter int DEPTH = 4,
    parameter logic [2:0] PROT = 3'b000
) (
    input  logic            m0_aclk,
    input  logic            m0_areset,
    output logic            m0_awvalid,
    input  logic            m0_awready,
    output logic [AW-1:0]   m0_awaddr,
    output logic [2:0]      m0_awprot,
    output logic            m0_wvalid,
    input  logic            m0_wready,
    output logic [DW-1:0]   m0_wdata,
    output logic [DW/8-1:0] m0_wstrb,
    input  logic            m0_bvalid,
    output logic            m0_bready,
    input  logic [1:0]      m0_bresp,
    output logic            m0_arvalid,
    input  logic            m0_arready,
    output logic [AW-1:0]   m0_araddr,
    output logic [2:0]      m0_arprot,
    input  logic            m0_rvalid,
    output logic            m0_rready,
    input  logic [1:0]      m0_rresp,
    input  logic [DW-1:0]   m0_rdata,
    input  logic            enable,
    input  logic            mem_req,
    output logic            mem_gnt,
    input  logic            mem_wen,
    input  logic [DW/8-1:0] mem_strb,
    input  logic [DW-1:0]   mem_wdata,
    input  logic [AW-1:0]   mem_addr,
    output logic            mem_recv,
    input  logic            mem_ack,
    output logic            mem_error,
    output logic [DW-1:0]   mem_rdata
);
    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0]   count;
    logic            dir, ar_pend, aw_pend, w_pend;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] strb;
    logic            cpu_req, cpu_rsp, hold_empty;
    logic            unused_resp;

    assign unused_resp = m0_bresp[0] ^ m0_rresp[0];

    always_comb begin
        hold_empty = !(ar_pend | aw_pend | w_pend);
        // a direction change only happens once everything outstanding has drained
        mem_gnt    = !m0_areset & enable & hold_empty & (count < CW'(DEPTH)) &
                     ((count == '0) | (dir == mem_wen));
        mem_recv   = (count != '0) & (dir ? m0_bvalid : m0_rvalid);
        cpu_req    = mem_req & mem_gnt;
        cpu_rsp    = mem_recv & mem_ack;
        m0_rready  = !dir & cpu_rsp;
        m0_bready  = dir & cpu_rsp;
        mem_error  = !m0_areset & (dir ? m0_bresp[1] : m0_rresp[1]);
        mem_rdata  = m0_rdata;
        m0_arvalid = ar_pend;
        m0_awvalid = aw_pend;
        m0_wvalid  = w_pend;
        m0_araddr  = addr;
        m0_awaddr  = addr;
        m0_wdata   = wdata;
        m0_wstrb   = strb;
        m0_arprot  = PROT;
        m0_awprot  = PROT;
    end

    always_ff @(posedge m0_aclk or posedge m0_areset) begin
        if (m0_areset) begin
            count   <= '0;
            dir     <= 1'b0;
            ar_pend <= 1'b0;
            aw_pend <= 1'b0;
            w_pend  <= 1'b0;
            addr    <= '0;
            wdata   <= '0;
            strb    <= '0;
        end else begin
            if (cpu_req) begin
                addr  <= mem_addr;
                wdata <= mem_wdata;
                strb  <= mem_strb;
                dir   <= mem_wen;
            end
            ar_pend <= cpu_req ? !mem_wen : ar_pend & !m0_arready;
            aw_pend <= cpu_req ? mem_wen : aw_pend & !m0_awready;
            w_pend  <= cpu_req ? mem_wen : w_pend & !m0_wready;
            count   <= count + CW'(cpu_req) - CW'(cpu_rsp);
        end
    end
endmodule

// File: tb/tb_ic_cpu_bus_axi_bridge_pipe.sv
// tb_ic_cpu_bus_axi_bridge_pipe: directed scenarios plus a randomized run against a
// transaction-level model of the bridge and an in-order AXI slave.
module tb_ic_cpu_bus_axi_bridge_pipe;
    localparam int DW = 32, AW = 32, DEPTH = 4;

    logic m0_aclk = 1'b0;
    logic m0_areset = 1'b1;
    logic m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
    logic m0_arvalid, m0_arready, m0_rvalid, m0_rready;
    logic [AW-1:0] m0_awaddr, m0_araddr, mem_addr;
    logic [2:0] m0_awprot, m0_arprot;
    logic [DW-1:0] m0_wdata, m0_rdata, mem_wdata, mem_rdata;
    logic [DW/8-1:0] m0_wstrb, mem_strb;
    logic [1:0] m0_bresp, m0_rresp;
    logic enable, mem_req, mem_gnt, mem_wen, mem_recv, mem_ack, mem_error;

    int checks = 0, errors = 0;

    ic_cpu_bus_axi_bridge_pipe #(.DW(DW), .AW(AW), .DEPTH(DEPTH), .PROT(3'b000)) dut (
        .m0_aclk(m0_aclk), .m0_areset(m0_areset),
        .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot),
        .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
        .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp),
        .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
        .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rresp(m0_rresp), .m0_rdata(m0_rdata),
        .enable(enable), .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_wen(mem_wen),
        .mem_strb(mem_strb), .mem_wdata(mem_wdata), .mem_addr(mem_addr),
        .mem_recv(mem_recv), .mem_ack(mem_ack), .mem_error(mem_error), .mem_rdata(mem_rdata)
    );

    always #5 m0_aclk = ~m0_aclk;

    function automatic logic [31:0] hsh(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'hA5A55A5A;
    endfunction

    task automatic idle();
        enable = 1'b1; mem_req = 1'b0; mem_wen = 1'b0; mem_addr = '0; mem_wdata = '0; mem_strb = '0;
        mem_ack = 1'b0; m0_awready = 1'b0; m0_wready = 1'b0; m0_arready = 1'b0;
        m0_bvalid = 1'b0; m0_rvalid = 1'b0; m0_bresp = 2'b00; m0_rresp = 2'b00; m0_rdata = '0;
    endtask

    task automatic test_reset();
        idle();
        m0_areset = 1'b1;
        @(negedge m0_aclk); #1;
        checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL rst_gnt got %b exp 0", mem_gnt); end
        checks++; if ({m0_arvalid, m0_awvalid, m0_wvalid} !== 3'b000) begin errors++; $display("FAIL rst_valids got %b exp 000", {m0_arvalid, m0_awvalid, m0_wvalid}); end
        checks++; if ({mem_recv, mem_error, m0_rready, m0_bready} !== 4'b0000) begin errors++; $display("FAIL rst_rsp got %b exp 0000", {mem_recv, mem_error, m0_rready, m0_bready}); end
        checks++; if ({m0_arprot, m0_awprot} !== 6'b0) begin errors++; $display("FAIL rst_prot got %b exp 0", {m0_arprot, m0_awprot}); end
        @(negedge m0_aclk); m0_areset = 1'b0; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL rst_gnt_after got %b exp 1", mem_gnt); end
    endtask

    task automatic test_single_read();
        @(negedge m0_aclk); mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h1000; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL sr_gnt got %b exp 1", mem_gnt); end
        @(negedge m0_aclk); mem_req = 1'b0; m0_arready = 1'b1; #1;
        checks++; if (m0_arvalid !== 1'b1 || m0_araddr !== 32'h1000) begin errors++; $display("FAIL sr_ar got %b/%h exp 1/00001000", m0_arvalid, m0_araddr); end
        @(negedge m0_aclk); m0_arready = 1'b0; #1;
        checks++; if (m0_arvalid !== 1'b0) begin errors++; $display("FAIL sr_ar_clear got %b exp 0", m0_arvalid); end
        @(negedge m0_aclk); m0_rvalid = 1'b1; m0_rdata = 32'hDEADBEEF; m0_rresp = 2'b00; mem_ack = 1'b1; #1;
        checks++; if ({mem_recv, m0_rready, mem_error} !== 3'b110 || mem_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL sr_rsp got recv/rready/err %b data %h exp 110 deadbeef", {mem_recv, m0_rready, mem_error}, mem_rdata); end
        @(negedge m0_aclk); m0_rvalid = 1'b0; mem_ack = 1'b0; mem_wen = 1'b1; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL sr_count_zero got gnt %b exp 1", mem_gnt); end
        mem_wen = 1'b0;
    endtask

    task automatic test_split_write();
        @(negedge m0_aclk); mem_req = 1'b1; mem_wen = 1'b1; mem_addr = 32'h20; mem_wdata = 32'h12345678; mem_strb = 4'hF; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL sw_gnt got %b exp 1", mem_gnt); end
        @(negedge m0_aclk); mem_req = 1'b0; m0_wready = 1'b1; #1;
        checks++; if ({m0_awvalid, m0_wvalid} !== 2'b11 || m0_wdata !== 32'h12345678 || m0_wstrb !== 4'hF) begin errors++; $display("FAIL sw_w got %b %h %h exp 11 12345678 f", {m0_awvalid, m0_wvalid}, m0_wdata, m0_wstrb); end
        for (int i = 0; i < 3; i++) begin
            @(negedge m0_aclk); m0_wready = 1'b0; m0_awready = (i == 2); #1;
            checks++; if ({m0_awvalid, m0_wvalid} !== 2'b10 || m0_awaddr !== 32'h20) begin errors++; $display("FAIL sw_aw_hold%0d got %b %h exp 10 00000020", i, {m0_awvalid, m0_wvalid}, m0_awaddr); end
        end
        @(negedge m0_aclk); m0_awready = 1'b0; mem_wen = 1'b0; #1;
        checks++; if ({m0_awvalid, mem_gnt} !== 2'b00) begin errors++; $display("FAIL sw_drain got aw/gnt %b exp 00", {m0_awvalid, mem_gnt}); end
        @(negedge m0_aclk); m0_bvalid = 1'b1; m0_bresp = 2'b10; mem_ack = 1'b1; #1;
        checks++; if ({mem_recv, mem_error, m0_bready, m0_rready} !== 4'b1110) begin errors++; $display("FAIL sw_bresp got %b exp 1110", {mem_recv, mem_error, m0_bready, m0_rready}); end
        @(negedge m0_aclk); m0_bvalid = 1'b0; m0_bresp = 2'b00; mem_ack = 1'b0; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL sw_count_zero got gnt %b exp 1", mem_gnt); end
    endtask

    task automatic test_pipeline();
        int g = 0;
        m0_arready = 1'b1; mem_wen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge m0_aclk); mem_req = 1'b1; mem_addr = 32'h100 + 32'(4 * g); #1;
            if (mem_gnt) g++;
        end
        checks++; if (g !== 4 || mem_gnt !== 1'b0) begin errors++; $display("FAIL pl_grants got %0d gnt %b exp 4 0", g, mem_gnt); end
        for (int k = 0; k < 4; k++) begin
            @(negedge m0_aclk); mem_req = 1'b0; m0_arready = 1'b0; mem_wen = 1'b1; m0_rvalid = 1'b1; m0_rdata = hsh(32'(k)); mem_ack = 1'b1; #1;
            checks++; if ({mem_recv, m0_rready, mem_gnt} !== 3'b110 || mem_rdata !== hsh(32'(k))) begin errors++; $display("FAIL pl_beat%0d got %b %h exp 110 %h", k, {mem_recv, m0_rready, mem_gnt}, mem_rdata, hsh(32'(k))); end
        end
        @(negedge m0_aclk); m0_rvalid = 1'b0; mem_ack = 1'b0; #1;
        checks++; if ({mem_recv, mem_gnt} !== 2'b01) begin errors++; $display("FAIL pl_drained got recv/gnt %b exp 01", {mem_recv, mem_gnt}); end
        mem_wen = 1'b0;
    endtask

    task automatic test_backpressure();
        @(negedge m0_aclk); mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h44; m0_arready = 1'b1;
        @(negedge m0_aclk); mem_req = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge m0_aclk); m0_arready = 1'b0; m0_rvalid = 1'b1; m0_rdata = 32'hCAFE0000 + 32'(i); mem_ack = 1'b0; mem_wen = 1'b1; #1;
            checks++; if ({mem_recv, m0_rready, mem_gnt} !== 3'b100) begin errors++; $display("FAIL bp_hold%0d got %b exp 100", i, {mem_recv, m0_rready, mem_gnt}); end
        end
        @(negedge m0_aclk); mem_ack = 1'b1; #1;
        checks++; if (m0_rready !== 1'b1) begin errors++; $display("FAIL bp_ack got rready %b exp 1", m0_rready); end
        @(negedge m0_aclk); m0_rvalid = 1'b0; mem_ack = 1'b0; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL bp_count_zero got gnt %b exp 1", mem_gnt); end
        mem_wen = 1'b0;
    endtask

    task automatic test_dir_switch();
        m0_arready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge m0_aclk); mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h200 + 32'(i); #1;
            checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL ds_rd_gnt%0d got %b exp 1", i, mem_gnt); end
            @(negedge m0_aclk); mem_req = 1'b0;
        end
        @(negedge m0_aclk); m0_arready = 1'b0; mem_req = 1'b1; mem_wen = 1'b1; #1;
        checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL ds_block got %b exp 0", mem_gnt); end
        for (int i = 0; i < 2; i++) begin
            @(negedge m0_aclk); m0_rvalid = 1'b1; mem_ack = 1'b1; #1;
            checks++; if ({mem_gnt, m0_rready} !== 2'b01) begin errors++; $display("FAIL ds_rsp%0d got gnt/rready %b exp 01", i, {mem_gnt, m0_rready}); end
        end
        @(negedge m0_aclk); m0_rvalid = 1'b0; mem_ack = 1'b0; #1;
        checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL ds_switch got %b exp 1", mem_gnt); end
        @(negedge m0_aclk); mem_req = 1'b0; m0_awready = 1'b1; m0_wready = 1'b1; #1;
        checks++; if ({m0_awvalid, m0_wvalid, m0_arvalid} !== 3'b110) begin errors++; $display("FAIL ds_wr_valid got %b exp 110", {m0_awvalid, m0_wvalid, m0_arvalid}); end
        @(negedge m0_aclk); m0_awready = 1'b0; m0_wready = 1'b0; m0_bvalid = 1'b1; mem_ack = 1'b1; #1;
        checks++; if (m0_bready !== 1'b1) begin errors++; $display("FAIL ds_bready got %b exp 1", m0_bready); end
        @(negedge m0_aclk); m0_bvalid = 1'b0; mem_ack = 1'b0; mem_wen = 1'b0;
    endtask

    task automatic test_reset_mid();
        @(negedge m0_aclk); mem_req = 1'b1; mem_wen = 1'b0; mem_addr = 32'h300;
        @(negedge m0_aclk); mem_req = 1'b0; #1;
        checks++; if (m0_arvalid !== 1'b1) begin errors++; $display("FAIL rm_arvalid got %b exp 1", m0_arvalid); end
        #1 m0_areset = 1'b1; #1;
        checks++; if (m0_arvalid !== 1'b0) begin errors++; $display("FAIL rm_async got %b exp 0", m0_arvalid); end
        @(negedge m0_aclk); m0_areset = 1'b0; m0_rvalid = 1'b1; mem_ack = 1'b1; #1;
        checks++; if ({mem_recv, m0_rready} !== 2'b00) begin errors++; $display("FAIL rm_stray got recv/rready %b exp 00", {mem_recv, m0_rready}); end
        @(negedge m0_aclk); m0_rvalid = 1'b0; mem_ack = 1'b0;
    endtask

    typedef struct {logic wr; logic [31:0] addr, data; logic [3:0] strb;} txn_t;

    task automatic test_random();
        txn_t cur, sq[$];
        logic ap = 1'b0, wp = 1'b0, mdir = 1'b0, rsp_on = 1'b0, exp_gnt, fw, was;
        logic [1:0] rsp_resp = 2'b00;
        int cnt = 0, nrsp = 0;
        cur = '{1'b0, 32'h0, 32'h0, 4'h0};
        idle();
        @(negedge m0_aclk); m0_areset = 1'b1;
        @(negedge m0_aclk); m0_areset = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            @(negedge m0_aclk);
            enable = ($urandom_range(0, 9) != 0);
            mem_req = $urandom_range(0, 1);
            mem_wen = ($urandom_range(0, 7) == 0) ? !mem_wen : mem_wen;
            mem_addr = $urandom; mem_wdata = $urandom; mem_strb = 4'($urandom);
            m0_arready = $urandom_range(0, 1); m0_awready = $urandom_range(0, 1); m0_wready = $urandom_range(0, 1);
            if (!rsp_on && sq.size() > 0 && $urandom_range(0, 3) == 0) begin
                rsp_on = 1'b1; rsp_resp = 2'($urandom);
            end
            fw = (sq.size() > 0) ? sq[0].wr : 1'b0;
            m0_rvalid = rsp_on & !fw; m0_bvalid = rsp_on & fw;
            m0_rdata = (sq.size() > 0) ? hsh(sq[0].addr) : $urandom;
            m0_rresp = rsp_resp; m0_bresp = rsp_resp;
            mem_ack = $urandom_range(0, 1);
            #1;
            exp_gnt = enable & !ap & !wp & (cnt < DEPTH) & ((cnt == 0) | (mdir == mem_wen));
            checks++; if (mem_gnt !== exp_gnt) begin errors++; $display("FAIL rnd_gnt c%0d got %b exp %b", c, mem_gnt, exp_gnt); end
            checks++; if ({m0_arvalid, m0_awvalid, m0_wvalid} !== {ap & !mdir, ap & mdir, wp}) begin errors++; $display("FAIL rnd_valids c%0d got %b exp %b", c, {m0_arvalid, m0_awvalid, m0_wvalid}, {ap & !mdir, ap & mdir, wp}); end
            if (ap) begin
                checks++; if ((mdir ? m0_awaddr : m0_araddr) !== cur.addr) begin errors++; $display("FAIL rnd_addr c%0d got %h exp %h", c, mdir ? m0_awaddr : m0_araddr, cur.addr); end
            end
            if (wp) begin
                checks++; if (m0_wdata !== cur.data || m0_wstrb !== cur.strb) begin errors++; $display("FAIL rnd_wdata c%0d got %h/%h exp %h/%h", c, m0_wdata, m0_wstrb, cur.data, cur.strb); end
            end
            checks++; if ({mem_recv, m0_rready, m0_bready} !== {rsp_on, rsp_on & !fw & mem_ack, rsp_on & fw & mem_ack}) begin errors++; $display("FAIL rnd_rsp c%0d got %b exp %b", c, {mem_recv, m0_rready, m0_bready}, {rsp_on, rsp_on & !fw & mem_ack, rsp_on & fw & mem_ack}); end
            if (rsp_on) begin
                checks++; if (mem_error !== rsp_resp[1] || (!fw && mem_rdata !== hsh(sq[0].addr))) begin errors++; $display("FAIL rnd_data c%0d got %b/%h exp %b/%h", c, mem_error, mem_rdata, rsp_resp[1], hsh(sq[0].addr)); end
            end
            if (rsp_on && mem_ack) begin
                void'(sq.pop_front()); rsp_on = 1'b0; cnt--; nrsp++;
            end
            was = ap | wp;
            if (ap && (mdir ? m0_awready : m0_arready)) ap = 1'b0;
            if (wp && m0_wready) wp = 1'b0;
            if (was && !ap && !wp) sq.push_back(cur);
            if (exp_gnt && mem_req) begin
                cur = '{mem_wen, mem_addr, mem_wdata, mem_strb};
                ap = 1'b1; wp = mem_wen; mdir = mem_wen; cnt++;
            end
        end
        checks++; if (nrsp < 50) begin errors++; $display("FAIL rnd_activity got %0d responses exp >=50", nrsp); end
        idle();
    endtask

    initial begin
        idle();
        test_reset();
        test_single_read();
        test_split_write();
        test_pipeline();
        test_backpressure();
        test_dir_switch();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
